mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU's MUL operation (ALU control code 3'b110), located in the EX stage.
- On detecting a valid MUL it stalls the pipeline and runs a radix-2 shift-add multiply over DATA_W cycles.
- It presents the low DATA_W bits of the product for exactly one cycle, the cycle in which the stall releases.
- All other ALU control codes pass through untouched; the block does nothing for them.

Parameters:
- DATA_W, 32: operand and result width.
- MUL_CODE, 3'b110: ALU control value that selects multiply.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: asynchronous active-low reset.
- ex_valid_i, input, 1: EX stage holds a real, non-bubble instruction.
- ALUCtrl_i, input, 3: ALU control code of the EX instruction.
- flush_i, input, 1: kill the EX instruction (branch/exception); aborts the multiply.
- op1_i, input, DATA_W: rs1 operand (multiplicand).
- op2_i, input, DATA_W: rs2 operand (multiplier).
- stall_o, output, 1: freezes PC, IF/ID and ID/EX.
- busy_o, output, 1: sequencer is in RUN.
- done_o, output, 1: product_o is valid this cycle.
- product_o, output, DATA_W: low DATA_W bits of op1*op2.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_i.
- Reset values: state=IDLE; stall_o=0, busy_o=0, done_o=0, product_o=0; internal accumulator, multiplicand, multiplier and count all 0.
- start = ex_valid_i && (ALUCtrl_i==MUL_CODE) && !flush_i, evaluated only in IDLE.
- IDLE:
  - stall_o = start (combinational), so the MUL is held in EX in the detect cycle T.
  - On start: latch mcand=op1_i, mplr=op2_i, acc=0, cnt=0, then go to RUN.
- RUN:
  - Each cycle: if mplr[0], acc <= acc + mcand (mod 2^DATA_W); then mcand <<= 1, mplr >>= 1, cnt++.
  - After DATA_W iterations go to DONE. Latency is fixed; there is no early termination.
  - stall_o=1 and busy_o=1 throughout.
- DONE:
  - done_o=1, stall_o=0, and product_o = acc, so the ID/EX → EX/MEM edge captures the result.
  - Go to IDLE unconditionally. The MUL has left EX, so the block never re-triggers on the same instruction.
- Timing: detect at cycle T; RUN is T+1..T+DATA_W; DONE is T+DATA_W+1. stall_o is high for exactly DATA_W+1 cycles (T..T+DATA_W).
- product_o holds its last value until the next start clears it. Consumers qualify it with done_o.
- Signedness: low half only, so signed and unsigned give identical results. No sign handling.
- flush_i:
  - In IDLE it suppresses start.
  - In RUN, IDLE is reached on the next edge; done_o never pulses, and stall_o drops combinationally in the flush cycle.
  - In DONE it has no effect (the result is discarded downstream).
- Back-to-back MULs: the second MUL reaches EX in the cycle after DONE, and IDLE detects it normally. There is no dead cycle beyond DONE.
- Reset asserted mid-RUN: immediate return to reset values. No done_o follows reset release.
- Operand changes during RUN are ignored, since the operands were latched.
- Non-MUL codes, or ex_valid_i=0: stall_o stays 0 and state stays IDLE.

Decomposition:
- Shared package (alu_pkg) holds:
  - ALU control code constants: NOP 000, AND 001, XOR 010, SLL 011, ADD 100, SUB 101, MUL 110, SRAI 111.
  - The ALUOp encodings.
  - The sequencer state enum: IDLE, RUN, DONE.
- The ALU control decoder and this block both import the same package.
- One sub-module, mul_shift_add_dp: acc/mcand/mplr registers plus adder, with load/step controls.
- mul_seq_ctrl keeps the FSM, the counter, and stall/done generation.

Test Plan:
- Basic multiply: op1=7, op2=6, MUL valid at T → stall_o high T..T+32; done_o=1 and product_o=42 at T+33; stall_o=0 at T+33.
- Signed wrap: op1=32'hFFFFFFFF, op2=3 → product_o=32'hFFFFFFFD. Overflow case: op1=op2=32'h00010000 → product_o=0.
- Non-MUL: ALUCtrl_i=3'b100 (ADD) with ex_valid_i=1, then MUL with ex_valid_i=0 → stall_o, busy_o and done_o stay 0 throughout.
- Flush: flush_i pulsed at T+10 during RUN → state IDLE at T+11, no done_o, stall_o=0 from T+10 on. A new MUL 5*5 then gives 25 after a full 33-cycle latency.
- Back-to-back: MUL 3*4 then MUL 9*9 in consecutive instructions → done_o with 12 at T+33, second detect at T+34, done_o with 81 at T+67.
- Reset mid-op: rst_i low at T+20 → all outputs 0 immediately. After release with no MUL pending, done_o is never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions: control codes, ALUOp encodings and
//                the multiply sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control codes driven by the ALU control decoder
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_MUL  = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mul_shift_add_dp
//  Description : Radix-2 shift-add multiply datapath. load captures the
//                operands and clears the accumulator; step performs one
//                conditional add followed by the operand shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add_dp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] acc_next
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;

  // Accumulator after the current iteration; only the low DATA_W bits are kept
  assign acc_next = mplr[0] ? (acc + mcand) : acc;

  // Operand capture on load, one shift-add iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= op1;
      mplr  <= op2;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

endmodule : mul_shift_add_dp
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : EX-stage sequencer for the ALU MUL operation. Stalls the
//                pipeline for DATA_W+1 cycles while a shift-add datapath
//                forms the low half of the product, then presents it for one
//                cycle alongside done_o as the stall releases.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter logic [2:0]  MUL_CODE = ALU_MUL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  seq_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              load;
  logic              step;
  logic [DATA_W-1:0] acc_next;

  assign start = ex_valid_i && (ALUCtrl_i == MUL_CODE) && !flush_i;
  assign load  = (state == IDLE) && start;
  // A flushed RUN cycle does not iterate; the operation is abandoned anyway
  assign step  = (state == RUN) && !flush_i;

  mul_shift_add_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (load),
    .step     (step),
    .op1      (op1_i),
    .op2      (op2_i),
    .acc_next (acc_next)
  );

  // Stall holds the MUL in EX from the detect cycle until DONE; a flush
  // releases it in the same cycle
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = start;
      RUN:     stall_o = !flush_i;
      default: stall_o = 1'b0;
    endcase
  end

  // Sequencer FSM with iteration counter and registered status/result outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      product_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            busy_o    <= 1'b1;
            product_o <= '0;
          end
        end
        RUN: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state     <= DONE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              product_o <= acc_next;
            end
          end
        end
        DONE: begin
          // The MUL leaves EX on this edge, so there is nothing to re-detect
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : mul_seq_ctrl
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Self-checking bench for mul_seq_ctrl: directed vector table,
//                random operands against an arithmetic reference, and
//                hand-written flush, back-to-back and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

  localparam int          DATA_W  = 32;
  localparam logic [2:0]  MUL_OP  = 3'b110;
  localparam logic [2:0]  ADD_OP  = 3'b100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [2:0]        alu_ctrl;
  logic              flush;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              stall_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] product_o;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] last_product;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] expect_p;
  } vec_t;

  vec_t vecs[7];

  mul_seq_ctrl #(
    .DATA_W   (DATA_W),
    .MUL_CODE (MUL_OP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .ex_valid_i (ex_valid),
    .ALUCtrl_i  (alu_ctrl),
    .flush_i    (flush),
    .op1_i      (op1),
    .op2_i      (op2),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .product_o  (product_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference product: low DATA_W bits of the full-width arithmetic product
  function automatic logic [DATA_W-1:0] ref_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return full[DATA_W-1:0];
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0;
    alu_ctrl = 3'b000;
    flush    = 1'b0;
  endtask

  // Presents a MUL at the current cycle (called just after a rising edge) and
  // checks the full stall/busy/done timeline plus the result.
  task automatic run_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] exp_p, input bit flush_in_done);
    ex_valid = 1'b1;
    alu_ctrl = MUL_OP;
    flush    = 1'b0;
    op1      = a;
    op2      = b;
    for (int c = 0; c <= DATA_W; c++) begin
      @(negedge clk);
      check("stall_during_mul", stall_o, 1);
      check("busy_during_mul", busy_o, (c != 0) ? 1 : 0);
      check("done_before_end", done_o, 0);
      if (c == 0) check("product_hold", product_o, last_product);
      @(posedge clk); #1;
      op1 = $urandom;
      op2 = $urandom;
    end
    if (flush_in_done) flush = 1'b1;
    @(negedge clk);
    check("done_pulse", done_o, 1);
    check("stall_release", stall_o, 0);
    check("busy_in_done", busy_o, 0);
    check("product", product_o, exp_p);
    @(posedge clk); #1;
    idle_inputs();
    last_product = exp_p;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd7,          32'd6,          32'd42};
    vecs[1] = '{32'hFFFFFFFF,   32'd3,          32'hFFFFFFFD};
    vecs[2] = '{32'h00010000,   32'h00010000,   32'h0};
    vecs[3] = '{32'h0,          32'h00012345,   32'h0};
    vecs[4] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h1};
    vecs[5] = '{32'h80000000,   32'd2,          32'h0};
    vecs[6] = '{32'h12345678,   32'd1,          32'h12345678};

    rst_n = 1'b0;
    idle_inputs();
    op1 = '0;
    op2 = '0;
    last_product = '0;
    #12;
    check("reset_stall", stall_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_product", product_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 7; i++) run_mul(vecs[i].a, vecs[i].b, vecs[i].expect_p, 1'b0);

    // Non-MUL traffic, invalid MUL and flushed MUL must never start
    for (int c = 0; c < 15; c++) begin
      ex_valid = (c >= 5) ? 1'b0 : 1'b1;
      alu_ctrl = (c < 5) ? ADD_OP : MUL_OP;
      if (c >= 10) begin
        ex_valid = 1'b1;
        flush    = 1'b1;
      end
      @(negedge clk);
      check("nomul_stall", stall_o, 0);
      check("nomul_busy", busy_o, 0);
      check("nomul_done", done_o, 0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Flush during RUN at T+10
    ex_valid = 1'b1;
    alu_ctrl = MUL_OP;
    op1 = 32'd100;
    op2 = 32'd100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("flush_pre_stall", stall_o, 1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", stall_o, 0);
    check("flush_busy_still", busy_o, 1);
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("post_flush_busy", busy_o, 0);
      check("post_flush_done", done_o, 0);
      check("post_flush_stall", stall_o, 0);
      @(posedge clk); #1;
    end
    last_product = '0;
    run_mul(32'd5, 32'd5, 32'd25, 1'b0);

    // Back-to-back MULs, with a flush in the first DONE cycle that must be ignored
    run_mul(32'd3, 32'd4, 32'd12, 1'b1);
    run_mul(32'd9, 32'd9, 32'd81, 1'b0);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      logic [DATA_W-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom);
      run_mul(ra, rb, ref_mul(ra, rb), 1'b0);
    end

    // Reset asserted at T+20
    ex_valid = 1'b1;
    alu_ctrl = MUL_OP;
    op1 = 32'd11;
    op2 = 32'd13;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_product", product_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("post_rst_done", done_o, 0);
      check("post_rst_busy", busy_o, 0);
      @(posedge clk); #1;
    end
    last_product = '0;
    run_mul(32'd11, 32'd13, 32'd143, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_seq_ctrl
`default_nettype wire
